// File: rtl/credit_pkg.sv
// Shared types and defaults for the credit ledger.
//   ledger_state_e : IDLE (no credit), CREDIT (credit held), CHANGE (refunding)
//   Def*           : default parameter values for credit_ledger
//   min_u()        : unsigned minimum, used to size each change transfer
package credit_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StCredit = 2'd1,
    StChange = 2'd2
  } ledger_state_e;

  localparam int unsigned DefBalW       = 8;
  localparam int unsigned DefCoinW      = 4;
  localparam int unsigned DefMaxBal     = 200;
  localparam int unsigned DefChangeUnit = 5;

  function automatic int unsigned min_u(input int unsigned a, input int unsigned b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/credit_ledger_adder.sv
// Parameterised unsigned adder with carry-out.
//   a_i, b_i : N-bit operands
//   sum_o    : N-bit sum
//   carry_o  : carry out of the MSB
module credit_ledger_adder #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic [N-1:0] sum_o,
  output logic         carry_o
);

  assign {carry_o, sum_o} = {1'b0, a_i} + {1'b0, b_i};

endmodule

// File: rtl/credit_ledger.sv
// Coin credit ledger: accumulates coins up to a ceiling, deducts vend prices,
// and refunds remaining credit through a valid/ready change handshake.
//   clk, reset              : clock and synchronous active-high reset
//   coin_valid, coin_value  : decoded coin from the coin decoder
//   vend_req, price         : vend request pulse and item price
//   cancel                  : refund-all pulse
//   change_ready            : dispenser accepts change_amt this cycle
//   balance                 : registered current credit
//   coin_reject, vend_ok,
//   vend_fail, refund_done  : registered one-cycle status pulses
//   change_valid, change_amt: change offer to the dispenser
//   busy                    : refund in progress
module credit_ledger
  import credit_pkg::*;
#(
  parameter int unsigned BAL_W       = DefBalW,
  parameter int unsigned COIN_W      = DefCoinW,
  parameter int unsigned MAX_BAL     = DefMaxBal,
  parameter int unsigned CHANGE_UNIT = DefChangeUnit
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              coin_valid,
  input  logic [COIN_W-1:0] coin_value,
  input  logic              vend_req,
  input  logic [BAL_W-1:0]  price,
  input  logic              cancel,
  input  logic              change_ready,
  output logic [BAL_W-1:0]  balance,
  output logic              coin_reject,
  output logic              vend_ok,
  output logic              vend_fail,
  output logic              change_valid,
  output logic [BAL_W-1:0]  change_amt,
  output logic              busy,
  output logic              refund_done
);

  ledger_state_e    state_q, state_d;
  logic [BAL_W-1:0] balance_q, balance_d;
  logic             coin_reject_q, coin_reject_d;
  logic             vend_ok_q, vend_ok_d;
  logic             vend_fail_q, vend_fail_d;
  logic             refund_done_q, refund_done_d;

  logic [BAL_W-1:0] coin_ext;
  logic [BAL_W-1:0] coin_sum;
  logic             coin_carry;
  logic             coin_over;
  logic [BAL_W-1:0] change_amt_w;

  assign coin_ext = BAL_W'(coin_value);

  credit_ledger_adder #(
    .N(BAL_W)
  ) u_adder (
    .a_i    (balance_q),
    .b_i    (coin_ext),
    .sum_o  (coin_sum),
    .carry_o(coin_carry)
  );

  // Ceiling check on the full BAL_W+1 bit sum so a wrapped result can't slip under MAX_BAL.
  assign coin_over = {coin_carry, coin_sum} > (BAL_W + 1)'(MAX_BAL);

  assign change_amt_w = BAL_W'(min_u(32'(balance_q), CHANGE_UNIT));

  always_comb begin
    state_d       = state_q;
    balance_d     = balance_q;
    coin_reject_d = 1'b0;
    vend_ok_d     = 1'b0;
    vend_fail_d   = 1'b0;
    refund_done_d = 1'b0;

    unique case (state_q)
      StIdle, StCredit: begin
        if (cancel) begin
          // Cancel with no credit is a silent no-op, but still outranks any coin.
          if (balance_q != '0) state_d = StChange;
          coin_reject_d = coin_valid;
        end else if (vend_req) begin
          if (balance_q >= price) begin
            vend_ok_d = 1'b1;
            balance_d = balance_q - price;
            state_d   = (balance_d != '0) ? StChange : StIdle;
          end else begin
            vend_fail_d = 1'b1;
          end
          coin_reject_d = coin_valid;
        end else if (coin_valid) begin
          if (coin_over) begin
            coin_reject_d = 1'b1;
          end else begin
            balance_d = coin_sum;
            state_d   = (coin_sum != '0) ? StCredit : StIdle;
          end
        end
      end

      StChange: begin
        // vend_req and cancel are ignored while refunding.
        coin_reject_d = coin_valid;
        if (change_ready) begin
          balance_d = balance_q - change_amt_w;
          if (balance_d == '0) begin
            state_d       = StIdle;
            refund_done_d = 1'b1;
          end
        end
      end

      default: begin
        state_d   = StIdle;
        balance_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      balance_q     <= '0;
      coin_reject_q <= 1'b0;
      vend_ok_q     <= 1'b0;
      vend_fail_q   <= 1'b0;
      refund_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      balance_q     <= balance_d;
      coin_reject_q <= coin_reject_d;
      vend_ok_q     <= vend_ok_d;
      vend_fail_q   <= vend_fail_d;
      refund_done_q <= refund_done_d;
    end
  end

  assign balance      = balance_q;
  assign coin_reject  = coin_reject_q;
  assign vend_ok      = vend_ok_q;
  assign vend_fail    = vend_fail_q;
  assign refund_done  = refund_done_q;
  assign busy         = (state_q == StChange);
  assign change_valid = (state_q == StChange);
  assign change_amt   = change_amt_w;

endmodule

// File: doc/credit_ledger.md
Name: credit_ledger

Overview:
Parametrised successor to the 4-bit coin balance register.
- Accumulates coin credit in a BAL_W-bit ledger with a configurable ceiling.
- Deducts an item price on a vend request.
- Returns remaining credit as change through a valid/ready handshake, CHANGE_UNIT per transfer.
- Sits between the coin decoder / vend controller and the change dispenser.

Parameters:
BAL_W, 8, ledger and price width in bits
COIN_W, 4, coin value width in bits
MAX_BAL, 200, credit ceiling; must be ≤ 2^BAL_W−1
CHANGE_UNIT, 5, maximum credit returned per change handshake; must be ≥ 1

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
coin_valid  in  1  coin present this cycle
coin_value  in  COIN_W  decoded coin value
vend_req  in  1  vend request, single-cycle pulse
price  in  BAL_W  item price, sampled with vend_req
cancel  in  1  refund all credit, single-cycle pulse
change_ready  in  1  dispenser accepts change_amt
balance  out  BAL_W  current credit (registered)
coin_reject  out  1  one-cycle pulse, coin refused
vend_ok  out  1  one-cycle pulse, vend granted and price deducted
vend_fail  out  1  one-cycle pulse, insufficient credit
change_valid  out  1  change transfer offered
change_amt  out  BAL_W  amount offered = min(balance, CHANGE_UNIT)
busy  out  1  high in CHANGE state
refund_done  out  1  one-cycle pulse, CHANGE exits with balance 0

Behaviour:
- Reset (synchronous, active-high, takes effect at the next rising edge, overrides everything):
  - state=IDLE, balance=0.
  - All pulses=0, change_valid=0.
  - Applies mid-CHANGE too; any offered change is abandoned.
- States:
  - IDLE: balance==0.
  - CREDIT: balance>0.
  - CHANGE: refunding.
- Per-cycle priority in IDLE/CREDIT: cancel > vend_req > coin_valid. A coin that loses priority is refused with coin_reject.
- Coin:
  - Accept if balance+coin_value ≤ MAX_BAL, computed at BAL_W+1 bits with no wrap. balance updates next edge; IDLE→CREDIT if result >0.
  - Otherwise coin_reject pulses next cycle and balance is unchanged.
  - coin_value==0 is accepted with no state change.
- Vend:
  - If balance ≥ price: vend_ok pulses next cycle and balance←balance−price in the same edge. Go to CHANGE if the remainder is >0, else IDLE.
  - If balance < price: vend_fail pulses, balance and state unchanged.
  - price==0 with balance==0 gives vend_ok and stays IDLE.
- Cancel:
  - balance>0: go to CHANGE.
  - balance==0: no-op, no pulse.
- CHANGE:
  - change_valid=1, change_amt=min(balance, CHANGE_UNIT).
  - On an edge with change_valid&&change_ready, balance←balance−change_amt.
  - When balance reaches 0: IDLE, refund_done pulses the following cycle, change_valid low that cycle.
  - change_amt is held stable while change_ready is low.
  - Coins arriving in CHANGE get coin_reject; vend_req and cancel are ignored (no pulses).
- Latency: all pulses appear exactly 1 cycle after the causing input edge. balance is never combinational from inputs.
- Invariant: balance ≤ MAX_BAL at all times. vend_ok, vend_fail and coin_reject are one-cycle pulses only.

Decomposition:
- Package credit_pkg:
  - state enum (IDLE, CREDIT, CHANGE).
  - Default parameter constants.
  - min() helper function for change_amt.
- Sub-module: the codebase's parameterised adder (N=BAL_W) for the credit sum. Carry-out feeds the over-ceiling check.
- Subtraction and FSM stay in credit_ledger.

Test Plan:
- Coins 10,10,5 on consecutive cycles → balance 10,20,25; no coin_reject; state CREDIT.
- balance=198, coin 4 → coin_reject pulse, balance stays 198. Then coin 2 → balance 200.
- balance=25, vend_req price=12:
  - vend_ok; balance 13; CHANGE with change_amt 5.
  - change_ready held high → amounts 5,5,3; then balance 0, refund_done, IDLE.
- balance=8, vend_req price=9 → vend_fail, balance 8, state CREDIT.
- Same cycle cancel+vend_req+coin with balance=7 → cancel wins; coin_reject; no vend_ok; CHANGE offers 5.
  - Hold change_ready=0 for 3 cycles → change_amt stays 5.
  - Assert reset → next cycle balance 0, IDLE, change_valid 0.
